fg_multichannel_dds: RTL and testbench

// - NUM_CH-channel direct-digital-synthesis function generator: per-channel phase accumulator, square/saw/triangle/DC shaping, amplitude, offset, radix.
// - Adds shadow config with glitch-free commit at period wrap, N-period burst mode and phase-aligned multi-channel start.
// - Sine stays in the CORDIC path. Sits beside the existing generator and shares the system timer tick (sample_en_i).

---
 rtl/fg_multichannel_dds_pkg.sv | 32 +++
 rtl/fg_dds_channel.sv | 213 +++++++++++++++++++++
 rtl/fg_multichannel_dds.sv | 69 ++++++
 tb/tb_fg_multichannel_dds.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fg_multichannel_dds_pkg.sv
// Shared encodings for the multichannel DDS function generator:
// waveform modes, register map, mode bit positions and channel state.
package fg_multichannel_dds_pkg;

  localparam logic [2:0] MODE_DC     = 3'd0;
  localparam logic [2:0] MODE_SQUARE = 3'd1;
  localparam logic [2:0] MODE_SAW    = 3'd2;
  localparam logic [2:0] MODE_TRI    = 3'd3;

  localparam int MODE_RADIX_BIT = 3;
  localparam int MODE_BURST_BIT = 4;
  localparam int MODE_W         = 5;

  localparam logic [2:0] CFG_ADDR_MODE  = 3'd0;
  localparam logic [2:0] CFG_ADDR_INC   = 3'd1;
  localparam logic [2:0] CFG_ADDR_DUTY  = 3'd2;
  localparam logic [2:0] CFG_ADDR_AMP   = 3'd3;
  localparam logic [2:0] CFG_ADDR_OFF   = 3'd4;
  localparam logic [2:0] CFG_ADDR_BURST = 3'd5;
  localparam logic [2:0] CFG_ADDR_INIT  = 3'd6;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_RUN,
    CH_HOLD
  } ch_state_e;

  function automatic int ch_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fg_dds_channel.sv
// One DDS channel: shadow/active config, run FSM, phase accumulator,
// burst counter, waveform shaper and output saturator.
module fg_dds_channel
  import fg_multichannel_dds_pkg::*;
#(
  parameter int BITWIDTH       = 8,
  parameter int PHASE_BITWIDTH = 16,
  parameter int BURST_BITWIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      sample_en_i,
  input  logic                      we_i,
  input  logic [2:0]                addr_i,
  input  logic [PHASE_BITWIDTH-1:0] data_i,
  input  logic                      commit_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  output logic [BITWIDTH-1:0]       out_o,
  output logic                      valid_o,
  output logic                      wrap_o,
  output logic                      busy_o
);

  localparam int B = BITWIDTH;
  localparam int P = PHASE_BITWIDTH;
  localparam int N = BURST_BITWIDTH;
  localparam int W = BITWIDTH + 2;

  logic [MODE_W-1:0] sh_mode, ac_mode;
  logic [P-1:0]      sh_inc, ac_inc;
  logic [P-1:0]      sh_duty, ac_duty;
  logic [P-1:0]      sh_init, ac_init;
  logic [B-1:0]      sh_amp, ac_amp;
  logic [B-1:0]      sh_off, ac_off;
  logic [N-1:0]      sh_burst, ac_burst;
  logic              pending;

  ch_state_e         state;
  logic [P-1:0]      phase;
  logic [N-1:0]      bcnt;
  logic              smp_d;

  logic [P:0]        acc;
  logic              upd, carry, pend_eff, apply;
  logic              burst_on, last_wrap;
  logic [P-1:0]      init_eff;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sh_mode  <= '0;
      sh_inc   <= '0;
      sh_duty  <= '0;
      sh_amp   <= '0;
      sh_off   <= '0;
      sh_burst <= '0;
      sh_init  <= '0;
    end else if (we_i) begin
      case (addr_i)
        CFG_ADDR_MODE:  sh_mode  <= data_i[MODE_W-1:0];
        CFG_ADDR_INC:   sh_inc   <= data_i;
        CFG_ADDR_DUTY:  sh_duty  <= data_i;
        CFG_ADDR_AMP:   sh_amp   <= data_i[B-1:0];
        CFG_ADDR_OFF:   sh_off   <= data_i[B-1:0];
        CFG_ADDR_BURST: sh_burst <= data_i[N-1:0];
        CFG_ADDR_INIT:  sh_init  <= data_i;
        default: ;
      endcase
    end
  end

  assign acc      = {1'b0, phase} + {1'b0, ac_inc};
  assign upd      = (state == CH_RUN) && sample_en_i
                    && !start_i && !stop_i;
  assign carry    = upd && acc[P];
  assign pend_eff = pending | commit_i;
  assign burst_on = ac_mode[MODE_BURST_BIT]
                    && (ac_burst != '0);
  assign last_wrap = carry && burst_on
                     && (bcnt == ac_burst - N'(1));

  // Running channels only swap config on the wrapping sample
  always_comb begin
    apply = 1'b0;
    if (start_i && !stop_i) begin
      apply = pend_eff;
    end else if (state != CH_RUN) begin
      apply = pending;
    end else begin
      apply = carry && pend_eff;
    end
  end

  assign init_eff = apply ? sh_init : ac_init;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pending  <= 1'b0;
      ac_mode  <= '0;
      ac_inc   <= '0;
      ac_duty  <= '0;
      ac_amp   <= '0;
      ac_off   <= '0;
      ac_burst <= '0;
      ac_init  <= '0;
    end else begin
      pending <= pend_eff && !apply;
      if (apply) begin
        ac_mode  <= sh_mode;
        ac_inc   <= sh_inc;
        ac_duty  <= sh_duty;
        ac_amp   <= sh_amp;
        ac_off   <= sh_off;
        ac_burst <= sh_burst;
        ac_init  <= sh_init;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= CH_IDLE;
      phase  <= '0;
      bcnt   <= '0;
      wrap_o <= 1'b0;
    end else begin
      wrap_o <= carry;
      if (stop_i) begin
        state <= CH_IDLE;
      end else if (start_i) begin
        state <= CH_RUN;
        phase <= init_eff;
        bcnt  <= '0;
      end else if (upd) begin
        if (last_wrap) begin
          state <= CH_HOLD;
          phase <= init_eff;
          bcnt  <= '0;
        end else begin
          phase <= acc[P-1:0];
          if (carry && burst_on) begin
            bcnt <= bcnt + N'(1);
          end
        end
      end
    end
  end

  assign busy_o = (state == CH_RUN);

  logic [B-1:0]          p, ramp, sat, out_d;
  logic signed [B-1:0]   centered;
  logic signed [2*B:0]   c_ext, a_ext, prod;
  logic signed [W-1:0]   wave, sum, amp_s;
  logic                  is_sq, is_ramp, in_range;
  logic                  unused_lsb;

  assign p    = phase[P-1 -: B];
  assign ramp = (ac_mode[2:0] != MODE_TRI) ? p
              : p[B-1] ? {~p[B-2:0], 1'b0}
              : {p[B-2:0], 1'b0};

  // Flipping the MSB recentres the unsigned ramp around zero
  assign centered = {~ramp[B-1], ramp[B-2:0]};
  assign c_ext = {{(B+1){centered[B-1]}}, centered};
  assign a_ext = {{(B+1){1'b0}}, ac_amp};
  assign prod  = c_ext * a_ext;
  assign unused_lsb = ^prod[B-2:0];

  assign amp_s   = {2'b00, ac_amp};
  assign is_sq   = busy_o && (ac_mode[2:0] == MODE_SQUARE);
  assign is_ramp = busy_o && ((ac_mode[2:0] == MODE_SAW)
                   || (ac_mode[2:0] == MODE_TRI));

  always_comb begin
    wave = '0;
    unique case (1'b1)
      is_sq:   wave = (phase < ac_duty) ? amp_s : -amp_s;
      is_ramp: wave = prod[2*B:B-1];
      default: wave = '0;
    endcase
  end

  assign sum = wave + {{2{ac_off[B-1]}}, ac_off};
  assign in_range = (sum[W-1:B-1] == '0)
                    || (sum[W-1:B-1] == '1);

  always_comb begin
    sat = sum[B-1:0];
    if (!in_range) begin
      sat = sum[W-1] ? {1'b1, {(B-1){1'b0}}}
                     : {1'b0, {(B-1){1'b1}}};
    end
  end

  assign out_d = {sat[B-1] ^ ac_mode[MODE_RADIX_BIT],
                  sat[B-2:0]};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      smp_d   <= 1'b0;
      valid_o <= 1'b0;
      out_o   <= '0;
    end else begin
      smp_d   <= sample_en_i;
      valid_o <= smp_d;
      if (smp_d) begin
        out_o <= out_d;
      end
    end
  end

endmodule

// File: rtl/fg_multichannel_dds.sv
// Multichannel DDS function generator top: reset synchroniser,
// config write decode and per-channel output packing.
module fg_multichannel_dds
  import fg_multichannel_dds_pkg::*;
#(
  parameter int BITWIDTH       = 8,
  parameter int PHASE_BITWIDTH = 16,
  parameter int NUM_CH         = 2,
  parameter int BURST_BITWIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          sample_en_i,
  input  logic                          cfg_we_i,
  input  logic [ch_sel_w(NUM_CH)-1:0]   cfg_ch_i,
  input  logic [2:0]                    cfg_addr_i,
  input  logic [PHASE_BITWIDTH-1:0]     cfg_data_i,
  input  logic [NUM_CH-1:0]             commit_i,
  input  logic [NUM_CH-1:0]             start_i,
  input  logic [NUM_CH-1:0]             stop_i,
  output logic [NUM_CH*BITWIDTH-1:0]    out_o,
  output logic [NUM_CH-1:0]             valid_o,
  output logic [NUM_CH-1:0]             wrap_o,
  output logic [NUM_CH-1:0]             busy_o
);

  localparam int CH_W = ch_sel_w(NUM_CH);

  logic [1:0] rst_sync;
  logic       rst_n;

  // Assert immediately, release two clocks after rstn_i rises
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic we;

    assign we = cfg_we_i && (cfg_ch_i == CH_W'(k));

    fg_dds_channel #(
      .BITWIDTH       (BITWIDTH),
      .PHASE_BITWIDTH (PHASE_BITWIDTH),
      .BURST_BITWIDTH (BURST_BITWIDTH)
    ) u_ch (
      .clk_i       (clk_i),
      .rstn_i      (rst_n),
      .sample_en_i (sample_en_i),
      .we_i        (we),
      .addr_i      (cfg_addr_i),
      .data_i      (cfg_data_i),
      .commit_i    (commit_i[k]),
      .start_i     (start_i[k]),
      .stop_i      (stop_i[k]),
      .out_o       (out_o[k*BITWIDTH +: BITWIDTH]),
      .valid_o     (valid_o[k]),
      .wrap_o      (wrap_o[k]),
      .busy_o      (busy_o[k])
    );
  end

endmodule

// File: tb/tb_fg_multichannel_dds.sv
// Directed bench for fg_multichannel_dds: shaping, saturation,
// commit timing, burst, alignment, start/stop and reset.
module tb_fg_multichannel_dds;

  logic        clk;
  logic        rstn;
  logic        sample_en;
  logic        cfg_we;
  logic [0:0]  cfg_ch;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [1:0]  commit;
  logic [1:0]  start;
  logic [1:0]  stop;
  logic [15:0] out_o;
  logic [1:0]  valid_o;
  logic [1:0]  wrap_o;
  logic [1:0]  busy_o;

  int checks;
  int errors;
  int se_mode;

  fg_multichannel_dds #(
    .BITWIDTH       (8),
    .PHASE_BITWIDTH (16),
    .NUM_CH         (2),
    .BURST_BITWIDTH (8)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .sample_en_i (sample_en),
    .cfg_we_i    (cfg_we),
    .cfg_ch_i    (cfg_ch),
    .cfg_addr_i  (cfg_addr),
    .cfg_data_i  (cfg_data),
    .commit_i    (commit),
    .start_i     (start),
    .stop_i      (stop),
    .out_o       (out_o),
    .valid_o     (valid_o),
    .wrap_o      (wrap_o),
    .busy_o      (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 0: tick held low, 1: tick every cycle, 2: every other cycle
  initial begin
    sample_en = 1'b0;
    forever begin
      @(negedge clk);
      if (se_mode == 0) sample_en = 1'b0;
      else if (se_mode == 1) sample_en = 1'b1;
      else sample_en = ~sample_en;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic signed [7:0] o(input int ch);
    logic [15:0] v;
    v = out_o;
    return v[ch*8 +: 8];
  endfunction

  task automatic wr(input int ch, input logic [2:0] a,
                    input logic [15:0] d);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_ch = 1'(ch);
    cfg_addr = a;
    cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic cfg(input int ch, input logic [15:0] mode,
                     input logic [15:0] inc, input logic [15:0] duty,
                     input logic [15:0] amp, input logic [15:0] off,
                     input logic [15:0] burst, input logic [15:0] init);
    wr(ch, 3'd0, mode);
    wr(ch, 3'd1, inc);
    wr(ch, 3'd2, duty);
    wr(ch, 3'd3, amp);
    wr(ch, 3'd4, off);
    wr(ch, 3'd5, burst);
    wr(ch, 3'd6, init);
  endtask

  task automatic pulse(input logic [1:0] c, input logic [1:0] s,
                       input logic [1:0] p);
    @(negedge clk);
    commit = c;
    start = s;
    stop = p;
    @(negedge clk);
    commit = 2'b00;
    start = 2'b00;
    stop = 2'b00;
  endtask

  task automatic wait_wrap(input int ch, input int limit,
                           output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wrap_o[ch] && n < limit);
    if (!wrap_o[ch]) n = -1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_out got %h want 0000", out_o);
    end
    checks++;
    if ({valid_o, wrap_o, busy_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000",
               {valid_o, wrap_o, busy_o});
    end
    rstn = 1'b1;
    se_mode = 1;
    repeat (8) @(negedge clk);
    checks++;
    if (valid_o !== 2'b11 || out_o !== 16'h0
        || busy_o !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset got v=%b o=%h b=%b want 11 0000 00",
               valid_o, out_o, busy_o);
    end
  endtask

  task automatic test_square;
    int pos, neg, oth, wr_n, n;
    cfg(0, 16'd1, 16'h0100, 16'h8000, 16'd100, 16'd0, 16'd0, 16'h0);
    pulse(2'b01, 2'b00, 2'b00);
    repeat (2) @(negedge clk);
    pulse(2'b00, 2'b01, 2'b00);
    repeat (10) @(negedge clk);
    checks++;
    if (busy_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL sq_busy got %b want 1", busy_o[0]);
    end
    pos = 0; neg = 0; oth = 0; wr_n = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (valid_o[0]) begin
        if (o(0) == 100) pos++;
        else if (o(0) == -100) neg++;
        else oth++;
      end
      if (wrap_o[0]) wr_n++;
    end
    checks++;
    if (pos != 128 || neg != 128 || oth != 0) begin
      errors++;
      $display("FAIL sq_levels got +%0d -%0d other %0d want 128 128 0",
               pos, neg, oth);
    end
    checks++;
    if (wr_n != 1) begin
      errors++;
      $display("FAIL sq_wraps got %0d want 1", wr_n);
    end
    wait_wrap(0, 600, n);
    wait_wrap(0, 600, n);
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL sq_period got %0d want 256", n);
    end
  endtask

  task automatic test_sample_en;
    int cnt, n;
    se_mode = 0;
    repeat (3) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (valid_o[0] || wrap_o[0]) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL no_tick_activity got %0d want 0", cnt);
    end
    se_mode = 2;
    wait_wrap(0, 1200, n);
    wait_wrap(0, 1200, n);
    checks++;
    if (n != 512) begin
      errors++;
      $display("FAIL half_rate_period got %0d want 512", n);
    end
    se_mode = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_commit;
    int n, w1, w2;
    wait_wrap(0, 600, n);
    w1 = -1;
    w2 = -1;
    for (int i = 1; i <= 700; i++) begin
      @(negedge clk);
      if (i == 100) begin
        cfg_we = 1'b1;
        cfg_ch = 1'b0;
        cfg_addr = 3'd1;
        cfg_data = 16'h0200;
      end else if (i == 101) begin
        cfg_we = 1'b0;
        commit = 2'b01;
      end else if (i == 102) begin
        commit = 2'b00;
      end
      if (wrap_o[0]) begin
        if (w1 < 0) w1 = i;
        else if (w2 < 0) w2 = i;
      end
    end
    checks++;
    if (w1 != 256) begin
      errors++;
      $display("FAIL commit_old_inc_wrap got %0d want 256", w1);
    end
    checks++;
    if (w2 != 384) begin
      errors++;
      $display("FAIL commit_new_inc_wrap got %0d want 384", w2);
    end
    pulse(2'b00, 2'b00, 2'b01);
    repeat (3) @(negedge clk);
    wr(0, 3'd4, 16'h0030);
    pulse(2'b01, 2'b00, 2'b00);
    @(negedge clk);
    checks++;
    if (o(0) !== 8'sd0) begin
      errors++;
      $display("FAIL idle_commit_early got %0d want 0", o(0));
    end
    @(negedge clk);
    checks++;
    if (o(0) !== 8'sd48 || valid_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL idle_commit_apply got %0d v=%b want 48 v=1",
               o(0), valid_o[0]);
    end
  endtask

  task automatic collect(input int n, output int smax, output int smin,
                         output int umax, output int umin);
    smax = -1000; smin = 1000; umax = -1; umin = 1000;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (valid_o[0]) begin
        if (int'(o(0)) > smax) smax = int'(o(0));
        if (int'(o(0)) < smin) smin = int'(o(0));
        if (int'(out_o[7:0]) > umax) umax = int'(out_o[7:0]);
        if (int'(out_o[7:0]) < umin) umin = int'(out_o[7:0]);
      end
    end
  endtask

  task automatic test_shapes;
    int smax, smin, umax, umin;
    cfg(0, 16'd2, 16'h0100, 16'h8000, 16'd127, 16'd100, 16'd0, 16'h0);
    pulse(2'b01, 2'b00, 2'b00);
    repeat (2) @(negedge clk);
    pulse(2'b00, 2'b01, 2'b00);
    repeat (5) @(negedge clk);
    collect(300, smax, smin, umax, umin);
    checks++;
    if (smax != 127 || smin != -27) begin
      errors++;
      $display("FAIL saw_clamp got max %0d min %0d want 127 -27",
               smax, smin);
    end
    pulse(2'b00, 2'b00, 2'b01);
    wr(0, 3'd0, 16'd10);
    pulse(2'b01, 2'b00, 2'b00);
    repeat (2) @(negedge clk);
    pulse(2'b00, 2'b01, 2'b00);
    repeat (5) @(negedge clk);
    collect(300, smax, smin, umax, umin);
    checks++;
    if (umax != 255 || umin != 101) begin
      errors++;
      $display("FAIL saw_unsigned got max %0d min %0d want 255 101",
               umax, umin);
    end
    pulse(2'b00, 2'b00, 2'b01);
    wr(0, 3'd0, 16'd3);
    wr(0, 3'd4, 16'd0);
    pulse(2'b01, 2'b00, 2'b00);
    repeat (2) @(negedge clk);
    pulse(2'b00, 2'b01, 2'b00);
    repeat (5) @(negedge clk);
    collect(300, smax, smin, umax, umin);
    checks++;
    if (smax != 125 || smin != -127) begin
      errors++;
      $display("FAIL tri_range got max %0d min %0d want 125 -127",
               smax, smin);
    end
    pulse(2'b00, 2'b00, 2'b01);
  endtask

  task automatic test_burst;
    int nb, nw;
    cfg(0, 16'd17, 16'h4000, 16'h8000, 16'd50, 16'd20, 16'd3, 16'h0);
    pulse(2'b01, 2'b00, 2'b00);
    repeat (2) @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      pulse(2'b00, 2'b01, 2'b00);
      nb = 0;
      nw = 0;
      for (int i = 0; i < 40; i++) begin
        if (busy_o[0]) nb++;
        if (wrap_o[0]) nw++;
        @(negedge clk);
      end
      checks++;
      if (nb != 12 || nw != 3) begin
        errors++;
        $display("FAIL burst_run%0d got run %0d wraps %0d want 12 3",
                 r, nb, nw);
      end
      checks++;
      if (busy_o[0] !== 1'b0 || o(0) !== 8'sd20
          || valid_o[0] !== 1'b1) begin
        errors++;
        $display("FAIL burst_hold%0d got b=%b o=%0d v=%b want 0 20 1",
                 r, busy_o[0], o(0), valid_o[0]);
      end
    end
  endtask

  task automatic test_align;
    int bad, pos;
    pulse(2'b00, 2'b00, 2'b11);
    cfg(0, 16'd1, 16'h0100, 16'h8000, 16'd100, 16'd0, 16'd0, 16'h0);
    cfg(1, 16'd1, 16'h0100, 16'h8000, 16'd100, 16'd0, 16'd0, 16'h8000);
    pulse(2'b11, 2'b00, 2'b00);
    repeat (2) @(negedge clk);
    pulse(2'b00, 2'b11, 2'b00);
    repeat (3) @(negedge clk);
    bad = 0;
    pos = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (valid_o == 2'b11) begin
        if (o(1) !== -o(0)) bad++;
        if (o(0) == 100) pos++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL align_antiphase got %0d bad samples want 0", bad);
    end
    checks++;
    if (pos < 128 || pos > 172) begin
      errors++;
      $display("FAIL align_high_count got %0d want 128..172", pos);
    end
    pulse(2'b00, 2'b11, 2'b01);
    checks++;
    if (busy_o !== 2'b10) begin
      errors++;
      $display("FAIL stop_wins_run got %b want 10", busy_o);
    end
    pulse(2'b00, 2'b00, 2'b10);
    pulse(2'b00, 2'b01, 2'b01);
    checks++;
    if (busy_o !== 2'b00) begin
      errors++;
      $display("FAIL stop_wins_idle got %b want 00", busy_o);
    end
  endtask

  task automatic test_async_reset;
    int bad;
    cfg(0, 16'd17, 16'h0100, 16'h8000, 16'd50, 16'd20, 16'd3, 16'h0);
    pulse(2'b01, 2'b00, 2'b00);
    repeat (2) @(negedge clk);
    pulse(2'b00, 2'b01, 2'b00);
    repeat (100) @(negedge clk);
    checks++;
    if (busy_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL midburst_busy got %b want 1", busy_o[0]);
    end
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (out_o !== 16'h0 || busy_o !== 2'b00
        || valid_o !== 2'b00 || wrap_o !== 2'b00) begin
      errors++;
      $display("FAIL async_reset got o=%h b=%b v=%b w=%b want all 0",
               out_o, busy_o, valid_o, wrap_o);
    end
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_o !== 16'h0 || busy_o !== 2'b00 || wrap_o !== 2'b00)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_reset_quiet got %0d active cycles want 0", bad);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    se_mode = 0;
    rstn = 1'b0;
    cfg_we = 1'b0;
    cfg_ch = 1'b0;
    cfg_addr = 3'd0;
    cfg_data = 16'h0;
    commit = 2'b00;
    start = 2'b00;
    stop = 2'b00;
    test_reset();
    test_square();
    test_sample_en();
    test_commit();
    test_shapes();
    test_burst();
    test_align();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
